// File: rtl/gb_host_seq_if.sv
// Host-sequencer bundle: request/response streams plus the ghostbus localbus pins.
// master = the sequencer; slave = host/bus environment around it.
interface gb_host_seq_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic          gb_wen;
    logic          gb_rstb;
    logic [DW-1:0] gb_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready, gb_rdata,
        output req_ready, resp_valid, resp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, resp_ready, gb_rdata,
        input  req_ready, resp_valid, resp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb
    );
endinterface

// File: rtl/gb_host_seq.sv
// Turns a valid/ready request stream into one-cycle ghostbus strobes; writes take 2 cycles, reads return
// READ_DELAY+2 cycles after accept. One transaction in flight: req_ready low until IDLE, response held until resp_ready.
module gb_host_seq #(
    parameter int AW         = 24,
    parameter int DW         = 32,
    parameter int READ_DELAY = 3,
    parameter int CNTW       = 16
) (
    input  logic            gb_clk,
    input  logic            gb_rst_n,
    gb_host_seq_if.master   bus,
    output logic            busy,
    output logic [CNTW-1:0] wr_count,
    output logic [CNTW-1:0] rd_count
);
    localparam int WW = (READ_DELAY < 2) ? 1 : $clog2(READ_DELAY + 1);

    if (READ_DELAY < 1) begin : g_bad_read_delay
        $error("gb_host_seq: READ_DELAY must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, WRITE, READ_STB, READ_WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            wen_q, wen_d;
    logic            rstb_q, rstb_d;
    logic            rvld_q, rvld_d;
    logic [CNTW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNTW-1:0] rd_cnt_q, rd_cnt_d;

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wen_q    <= 1'b0;
            rstb_q   <= 1'b0;
            rvld_q   <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wen_q    <= wen_d;
            rstb_q   <= rstb_d;
            rvld_q   <= rvld_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Strobes and resp_valid are computed one state ahead so they leave flops directly.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        wen_d    = 1'b0;
        rstb_d   = 1'b0;
        rvld_d   = rvld_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        wdata_d = bus.req_wdata;
                        wen_d   = 1'b1;
                        state_d = WRITE;
                    end else begin
                        rstb_d  = 1'b1;
                        state_d = READ_STB;
                    end
                end
            end
            WRITE: begin
                wr_cnt_d = wr_cnt_q + CNTW'(1);
                state_d  = IDLE;
            end
            READ_STB: begin
                wait_d  = WW'(READ_DELAY);
                state_d = READ_WAIT;
            end
            READ_WAIT: begin
                // wait_q reaches 1 in the cycle the slave presents gb_rdata.
                if (wait_q == WW'(1)) begin
                    rdata_d = bus.gb_rdata;
                    rvld_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    rvld_d   = 1'b0;
                    rd_cnt_d = rd_cnt_q + CNTW'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = rvld_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.gb_addr    = addr_q;
    assign bus.gb_wdata   = wdata_q;
    assign bus.gb_wen     = wen_q;
    assign bus.gb_rstb    = rstb_q;
    assign busy           = (state_q != IDLE);
    assign wr_count       = wr_cnt_q;
    assign rd_count       = rd_cnt_q;
endmodule

// File: tb/tb_gb_host_seq.sv
// Directed bench: instance A (READ_DELAY=3, 16-bit counters) and instance B (READ_DELAY=1, 4-bit counters for wrap).
module tb_gb_host_seq;
    localparam int AW = 24;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gb_host_seq_if #(.AW(AW), .DW(DW)) ia ();
    gb_host_seq_if #(.AW(AW), .DW(DW)) ib ();

    logic        busy_a, busy_b;
    logic [15:0] wr_a, rd_a;
    logic [3:0]  wr_b, rd_b;

    gb_host_seq #(.AW(AW), .DW(DW), .READ_DELAY(3), .CNTW(16)) dut_a (
        .gb_clk(clk), .gb_rst_n(rst_n), .bus(ia), .busy(busy_a), .wr_count(wr_a), .rd_count(rd_a));
    gb_host_seq #(.AW(AW), .DW(DW), .READ_DELAY(1), .CNTW(4)) dut_b (
        .gb_clk(clk), .gb_rst_n(rst_n), .bus(ib), .busy(busy_b), .wr_count(wr_b), .rd_count(rd_b));

    // Slave models: memory plus a READ_DELAY-deep read pipeline; data is zero unless strobed.
    logic [DW-1:0] mem_a [0:255];
    logic [DW-1:0] mem_b [0:255];
    logic [DW-1:0] pipe_a [0:2];
    logic [DW-1:0] pipe_b;

    always @(posedge clk) begin
        if (ia.gb_wen) mem_a[ia.gb_addr[7:0]] <= ia.gb_wdata;
        pipe_a[0] <= ia.gb_rstb ? mem_a[ia.gb_addr[7:0]] : '0;
        pipe_a[1] <= pipe_a[0];
        pipe_a[2] <= pipe_a[1];
        if (ib.gb_wen) mem_b[ib.gb_addr[7:0]] <= ib.gb_wdata;
        pipe_b <= ib.gb_rstb ? mem_b[ib.gb_addr[7:0]] : '0;
    end
    assign ia.gb_rdata = pipe_a[2];
    assign ib.gb_rdata = pipe_b;

    int            cyc = 0;
    int            both_hi = 0;
    int            wq[$];
    logic [DW-1:0] rq[$];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ia.gb_wen && ia.gb_rstb) both_hi <= both_hi + 1;
        if (ia.gb_wen) wq.push_back(cyc);
        if (ia.resp_valid && ia.resp_ready) rq.push_back(ia.resp_rdata);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready_a(input string tag);
        int n = 0;
        while (!ia.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, ia.req_ready, 1);
    endtask

    task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ia.req_valid = 1'b1; ia.req_write = 1'b1; ia.req_addr = a; ia.req_wdata = d;
        @(negedge clk);
        ia.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_a(input logic [AW-1:0] a, output logic [DW-1:0] d);
        int n = 0;
        ia.req_valid = 1'b1; ia.req_write = 1'b0; ia.req_addr = a; ia.resp_ready = 1'b1;
        @(negedge clk);
        ia.req_valid = 1'b0;
        while (!ia.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        d = ia.resp_rdata;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int rbase, wbase, nresp;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        ia.req_valid = 0; ia.req_write = 0; ia.req_addr = '0; ia.req_wdata = '0; ia.resp_ready = 0;
        ib.req_valid = 0; ib.req_write = 0; ib.req_addr = '0; ib.req_wdata = '0; ib.resp_ready = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", ia.req_ready, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_wen", ia.gb_wen, 0);
        chk("rst_rstb", ia.gb_rstb, 0);
        chk("rst_resp_valid", ia.resp_valid, 0);
        chk("rst_addr", ia.gb_addr, 0);
        chk("rst_wdata", ia.gb_wdata, 0);
        chk("rst_rdata", ia.resp_rdata, 0);
        chk("rst_wr_count", wr_a, 0);
        chk("rst_rd_count", rd_a, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Single write
        ia.req_valid = 1; ia.req_write = 1; ia.req_addr = 24'h000004; ia.req_wdata = 32'h5;
        @(negedge clk);
        chk("wr_wen", ia.gb_wen, 1);
        chk("wr_addr", ia.gb_addr, 24'h4);
        chk("wr_wdata", ia.gb_wdata, 32'h5);
        chk("wr_ready_low", ia.req_ready, 0);
        chk("wr_no_rstb", ia.gb_rstb, 0);
        ia.req_valid = 0;
        @(negedge clk);
        chk("wr_wen_drop", ia.gb_wen, 0);
        chk("wr_ready_back", ia.req_ready, 1);
        chk("wr_count1", wr_a, 1);

        // Single read, response at T+4
        ia.req_valid = 1; ia.req_write = 0; ia.req_addr = 24'h000004; ia.req_wdata = 32'hdead; ia.resp_ready = 1;
        @(negedge clk);
        chk("rd_rstb_T", ia.gb_rstb, 1);
        chk("rd_no_wen", ia.gb_wen, 0);
        ia.req_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("rd_early_valid", ia.resp_valid, 0);
            chk("rd_rstb_once", ia.gb_rstb, 0);
        end
        @(negedge clk);
        chk("rd_valid_T4", ia.resp_valid, 1);
        chk("rd_data", ia.resp_rdata, 32'h5);
        @(negedge clk);
        chk("rd_valid_drop", ia.resp_valid, 0);
        chk("rd_count1", rd_a, 1);
        chk("rd_wdata_kept", ia.gb_wdata, 32'h5);

        // Response held under backpressure
        write_a(24'h000008, 32'h12345678);
        ia.req_valid = 1; ia.req_write = 0; ia.req_addr = 24'h000008; ia.resp_ready = 0;
        @(negedge clk);
        ia.req_valid = 0;
        for (int n = 0; n < 20 && !ia.resp_valid; n++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", ia.resp_valid, 1);
            chk("hold_data", ia.resp_rdata, 32'h12345678);
            chk("hold_ready_low", ia.req_ready, 0);
            chk("hold_rd_count", rd_a, 1);
            @(negedge clk);
        end
        ia.resp_ready = 1;
        @(negedge clk);
        chk("hold_release", ia.resp_valid, 0);
        chk("hold_rd_count2", rd_a, 2);

        // Back-to-back writes then reads from a clean reset
        rst_n = 0;
        #1;
        chk("rst2_wr_count", wr_a, 0);
        chk("rst2_rd_count", rd_a, 0);
        rbase = rq.size();
        wbase = wq.size();
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ia.req_valid = 1; ia.req_write = 1; ia.req_addr = 24'h20 + AW'(i); ia.req_wdata = 32'hd0 + DW'(i);
            wait_ready_a("b2b_wr_ready");
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            ia.req_valid = 1; ia.req_write = 0; ia.req_addr = 24'h20 + AW'(i);
            wait_ready_a("b2b_rd_ready");
            @(negedge clk);
        end
        ia.req_valid = 0;
        for (int n = 0; n < 20 && busy_a; n++) @(negedge clk);
        chk("b2b_idle", busy_a, 0);
        chk("b2b_nresp", rq.size() - rbase, 8);
        for (int i = 0; i < 8 && rbase + i < rq.size(); i++)
            chk("b2b_rdata", rq[rbase+i], 32'hd0 + i);
        for (int i = 1; i < 8 && wbase + i < wq.size(); i++)
            chk("b2b_wr_gap", wq[wbase+i] - wq[wbase+i-1], 2);
        chk("b2b_wr_count", wr_a, 8);
        chk("b2b_rd_count", rd_a, 8);
        chk("b2b_no_overlap", both_hi, 0);

        // Reset while the read strobe is high
        ia.req_valid = 1; ia.req_write = 0; ia.req_addr = 24'h4; ia.resp_ready = 1;
        @(negedge clk);
        chk("rstb_pre", ia.gb_rstb, 1);
        rst_n = 0; ia.req_valid = 0;
        #1;
        chk("rstb_drop", ia.gb_rstb, 0);
        @(negedge clk) rst_n = 1;
        @(negedge clk);

        // Reset during READ_WAIT
        ia.req_valid = 1; ia.req_write = 0; ia.req_addr = 24'h4;
        @(negedge clk);
        ia.req_valid = 0;
        @(negedge clk);
        chk("mid_busy_pre", busy_a, 1);
        rst_n = 0;
        #1;
        chk("mid_busy", busy_a, 0);
        chk("mid_rstb", ia.gb_rstb, 0);
        chk("mid_resp_valid", ia.resp_valid, 0);
        chk("mid_req_ready", ia.req_ready, 1);
        chk("mid_rd_count", rd_a, 0);
        nresp = rq.size();
        @(negedge clk) rst_n = 1;
        repeat (8) @(negedge clk);
        chk("mid_no_resp", rq.size(), nresp);
        read_a(24'h4, d);
        chk("mid_reread", d, 32'h5);
        chk("mid_rd_count1", rd_a, 1);

        // Instance B: counter wrap and READ_DELAY=1 timing
        for (int i = 0; i < 15; i++) begin
            ib.req_valid = 1; ib.req_write = 1; ib.req_addr = 24'h40 + AW'(i); ib.req_wdata = 32'h100 + DW'(i);
            @(negedge clk);
            ib.req_valid = 0;
            @(negedge clk);
        end
        chk("b_wr_count15", wr_b, 15);
        ib.req_valid = 1; ib.req_write = 1; ib.req_addr = 24'h4f; ib.req_wdata = 32'hcafe;
        @(negedge clk);
        ib.req_valid = 0;
        @(negedge clk);
        chk("b_wr_wrap", wr_b, 0);
        ib.req_valid = 1; ib.req_write = 0; ib.req_addr = 24'h4f; ib.resp_ready = 1;
        @(negedge clk);
        chk("b_rstb_T", ib.gb_rstb, 1);
        ib.req_valid = 0;
        @(negedge clk);
        chk("b_valid_T1", ib.resp_valid, 0);
        @(negedge clk);
        chk("b_valid_T2", ib.resp_valid, 1);
        chk("b_rdata", ib.resp_rdata, 32'hcafe);
        @(negedge clk);
        chk("b_rd_count", rd_b, 1);
        chk("b_idle", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gb_host_seq.md
Name: gb_host_seq

Overview:
- Upstream host sequencer that drives the ghostbus localbus port (gb_addr/gb_wdata/gb_wen/gb_rstb/gb_rdata) of the generated top.
- Converts a valid/ready request stream (addr, wdata, write flag) into correctly timed single-cycle write and read strobes.
- Waits the fixed bus read latency, captures gb_rdata, and returns it on a valid/ready response channel.
- One transaction outstanding at a time; replaces hand-driven localbus tasks in benches and soft-core bridges.

Parameters:
- AW, 24, address width; matches gb_addr.
- DW, 32, data width; matches gb_wdata/gb_rdata.
- READ_DELAY, 3, cycles from the gb_rstb cycle to the gb_rdata-valid cycle. Must be >= 1; a value of 0 is an elaboration error.
- CNTW, 16, width of the transaction counters.

Ports:
- gb_clk  in  1  bus clock; all logic is on the rising edge.
- gb_rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high on an edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  request address.
- req_wdata  in  DW  write data; ignored for reads.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DW  captured read data.
- gb_addr  out  AW  bus address.
- gb_wdata  out  DW  bus write data.
- gb_wen  out  1  write strobe.
- gb_rstb  out  1  read strobe.
- gb_rdata  in  DW  bus read data.
- busy  out  1  high whenever state != IDLE.
- wr_count  out  CNTW  completed writes; wraps.
- rd_count  out  CNTW  completed reads, counted at the response handshake; wraps.

Behaviour:
- Reset (async assert, release on the next gb_clk edge):
  - state = IDLE.
  - req_ready = 1 (combinational: high only in IDLE).
  - All other outputs = 0: gb_wen, gb_rstb, resp_valid, gb_addr, gb_wdata, resp_rdata, counters.
- All bus outputs are registered.
- States: IDLE, WRITE, READ_STB, READ_WAIT, RESP.
- IDLE: on accept, latch req_addr into gb_addr.
  - Write: latch req_wdata into gb_wdata and go to WRITE.
  - Read: go to READ_STB.
- WRITE: gb_wen = 1 for exactly this cycle. Then gb_wen -> 0, wr_count++, return to IDLE.
  - Write throughput: one write per 2 cycles.
- READ_STB: gb_rstb = 1 for exactly this cycle (cycle T). Load wait counter with READ_DELAY; go to READ_WAIT.
- READ_WAIT: count down once per cycle.
  - The edge ending cycle T+READ_DELAY captures gb_rdata into resp_rdata.
  - Go to RESP, so resp_valid is high from cycle T+READ_DELAY+1.
- RESP: resp_valid and resp_rdata are held stable until resp_ready is sampled high.
  - On that edge: resp_valid -> 0, rd_count++, go to IDLE.
  - resp_ready outside RESP is ignored.
- gb_addr holds its value from the accept edge until the next accept. gb_wdata holds until the next write accept.
- gb_wen and gb_rstb are never high in the same cycle. Each strobe is exactly one cycle per transaction.
- No pipelining: req_ready is low from the accept edge until the state returns to IDLE. A request held on req_valid waits.
- Counters wrap from 2^CNTW-1 to 0 silently.
- Reset mid-transaction: any in-flight strobe drops immediately (async). A pending response is discarded and not counted. The next transaction starts cleanly from IDLE.

Test Plan:
- Slave model: DW-wide memory with a READ_DELAY-stage read pipeline. Write addr 0x000004 data 0x5 -> gb_wen high exactly 1 cycle with gb_addr = 0x04, gb_wdata = 0x5; wr_count = 1; req_ready back high 2 cycles after accept.
- Read 0x000004 after that write, resp_ready = 1 -> gb_rstb 1 cycle at T; resp_valid at T+4 with resp_rdata = 0x5; rd_count = 1.
- Read with resp_ready held low 10 cycles -> resp_valid and resp_rdata stable all 10 cycles; req_ready = 0 throughout; single rd_count increment when resp_ready rises.
- Back-to-back: 8 writes to 0x20..0x27 with data 0xd0..0xd7, req_valid held high, then 8 reads -> writes every 2 cycles; reads return 0xd0..0xd7 in order; wr_count = 8, rd_count = 8; gb_wen and gb_rstb never high together.
- Assert gb_rst_n low during READ_WAIT -> gb_rstb, resp_valid and busy go 0 immediately; no response emerges; a subsequent read of 0x04 returns the correct data.
- READ_DELAY = 1 build, plus wr_count preset near 0xFFFF by 65536 writes (or forced) -> read response at T+2; counter wraps 0xFFFF -> 0x0000.
